// File: rtl/frame_arbiter_mux.sv
// Round-robin frame arbiter with a registered output stage.
// One input port is locked for a whole frame, from its first beat to the beat
// with in_last set. The arbitration decision is made only in IDLE, so every
// frame costs one idle cycle between frames.
module frame_arbiter_mux #(
  parameter int NUM_PORTS = 4,
  parameter int WIDTH     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_PORTS*WIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]       in_valid,
  input  logic [NUM_PORTS-1:0]       in_last,
  output logic [NUM_PORTS-1:0]       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic [NUM_PORTS-1:0]       grant,
  output logic                       busy
);

  localparam int PTR_W = $clog2(NUM_PORTS);
  localparam logic [PTR_W:0]   NP       = (PTR_W + 1)'(NUM_PORTS);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_PORTS - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [NUM_PORTS-1:0]   grant_q, grant_d;
  logic [WIDTH-1:0]       out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;

  logic                   advance;
  logic                   sel_found;
  logic [PTR_W-1:0]       sel_idx;
  logic [PTR_W:0]         cand;
  logic [PTR_W-1:0]       gnt_idx;
  logic [WIDTH-1:0]       g_data;
  logic                   g_last;
  logic                   xfer;

  // The output register may take a new beat when it is empty or being drained.
  assign advance = !out_valid_q || out_ready;

  // Only the locked port sees ready, and only when the output register can advance.
  assign in_ready = (state_q == LOCKED && advance) ? grant_q : '0;
  assign xfer     = |(in_valid & in_ready);

  // First requesting port at or after ptr, wrapping past NUM_PORTS-1 for any port count.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = {1'b0, ptr_q} + (PTR_W + 1)'(k);
      if (cand >= NP) cand = cand - NP;
      if (!sel_found && in_valid[cand[PTR_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // AND-OR mux of the granted port's data and last flag, plus its index.
  always_comb begin
    gnt_idx = '0;
    g_data  = '0;
    g_last  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q[i]) begin
        gnt_idx = PTR_W'(i);
        g_data  = g_data | in_data[i*WIDTH +: WIDTH];
        g_last  = g_last | in_last[i];
      end
    end
  end

  // Next-state logic: arbitration in IDLE, frame tracking in LOCKED, output register advance.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    // A stalled output register holds everything; an advancing one loads or empties.
    if (advance) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = g_data;
        out_last_d = g_last;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          state_d          = LOCKED;
        end
      end
      LOCKED: begin
        // Grant is released only by the last beat of the frame, never by other requests.
        if (xfer && g_last) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PTR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset clears the partial frame and restarts arbitration at port 0.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign grant     = grant_q;
  assign busy      = (state_q == LOCKED);

endmodule
